dmem_ctrl: RTL and testbench

//  Two-requester access controller in front of the single-port 2 KB data memory. Arbitrates

---
 rtl/dmem_ctrl.sv | 128 ++++++++++++
 tb/tb_dmem_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: round-robin two-port controller for the single-port data memory with sub-word read-modify-write
module dmem_ctrl #(
  parameter int MEM_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [1:0]  req0_size,
  input  logic        req0_unsigned,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [1:0]  req1_size,
  input  logic        req1_unsigned,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen,
  output logic        mem_ren,
  input  logic [31:0] mem_rdata
);
  typedef enum logic {IDLE, MERGE} state_t;
  localparam logic [29:0] LIMIT = 30'(MEM_WORDS);
  state_t state, state_n;
  logic pref, gnt_v, gnt, s_we, s_uns, s_err, fin, fin_port, fin_err, m_port;
  logic [1:0] s_size, m_size;
  logic [31:0] s_addr, s_wdata, fin_data, m_addr, m_wdata, m_word;

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] sz, input logic [1:0] a, input logic u);
    logic [7:0] b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    return sz == 2'b00 ? {{24{b[7] & ~u}}, b} : sz == 2'b01 ? {{16{h[15] & ~u}}, h} : w;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] sz, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] m;
    m = w;
    if (sz == 2'b00) m[{a, 3'b000} +: 8] = d[7:0];
    else m[{a[1], 4'b0000} +: 16] = d[15:0];
    return m;
  endfunction

  // arbitration, memory port drive and next state
  always_comb begin
    gnt_v = !rst && state == IDLE && (req0_valid || req1_valid);
    gnt = req1_valid && (!req0_valid || pref);
    s_we = gnt ? req1_we : req0_we;
    s_size = gnt ? req1_size : req0_size;
    s_uns = gnt ? req1_unsigned : req0_unsigned;
    s_addr = gnt ? req1_addr : req0_addr;
    s_wdata = gnt ? req1_wdata : req0_wdata;
    s_err = s_size == 2'b11 || (s_size == 2'b01 && s_addr[0]) || (s_size == 2'b10 && s_addr[1:0] != 2'b00) || s_addr[31:2] >= LIMIT;
    req0_ready = gnt_v && !gnt;
    req1_ready = gnt_v && gnt;
    mem_addr = '0;
    mem_wdata = '0;
    mem_wen = 1'b0;
    mem_ren = 1'b0;
    state_n = IDLE;
    if (state == MERGE && !rst) begin
      mem_wen = 1'b1;
      mem_addr = {m_addr[31:2], 2'b00};
      mem_wdata = merge(m_word, m_size, m_addr[1:0], m_wdata);
    end else if (gnt_v && !s_err) begin
      mem_addr = {s_addr[31:2], 2'b00};
      mem_wen = s_we && s_size == 2'b10;
      mem_ren = !(s_we && s_size == 2'b10);
      mem_wdata = s_we && s_size == 2'b10 ? s_wdata : '0;
      state_n = s_we && s_size != 2'b10 ? MERGE : IDLE;
    end
  end

  // completion info for the response registers; kept apart from the address path because it consumes mem_rdata
  always_comb begin
    fin = state == MERGE || (gnt_v && state_n == IDLE);
    fin_port = state == MERGE ? m_port : gnt;
    fin_err = state == IDLE && s_err;
    fin_data = state == IDLE && !s_err && !s_we ? ext(mem_rdata, s_size, s_addr[1:0], s_uns) : '0;
  end

  // state, round-robin pointer, merge context and registered responses
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pref <= 1'b0;
      m_port <= 1'b0;
      m_addr <= '0;
      m_size <= '0;
      m_wdata <= '0;
      m_word <= '0;
      rsp0_valid <= 1'b0;
      rsp0_err <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_valid <= 1'b0;
      rsp1_err <= 1'b0;
      rsp1_rdata <= '0;
    end else begin
      state <= state_n;
      rsp0_valid <= fin && !fin_port;
      rsp1_valid <= fin && fin_port;
      rsp0_err <= fin && !fin_port && fin_err;
      rsp1_err <= fin && fin_port && fin_err;
      rsp0_rdata <= fin && !fin_port ? fin_data : '0;
      rsp1_rdata <= fin && fin_port ? fin_data : '0;
      if (gnt_v) pref <= !gnt;
      if (state_n == MERGE) begin
        m_port <= gnt;
        m_addr <= s_addr;
        m_size <= s_size;
        m_wdata <= s_wdata;
        m_word <= mem_rdata;
      end
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized and directed checks of dmem_ctrl against a byte-array reference memory
module tb_dmem_ctrl;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req0_ready, req0_we = 0, req0_unsigned = 0;
  logic [1:0] req0_size = 0;
  logic [31:0] req0_addr = 0, req0_wdata = 0;
  logic rsp0_valid, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic req1_valid = 0, req1_ready, req1_we = 0, req1_unsigned = 0;
  logic [1:0] req1_size = 0;
  logic [31:0] req1_addr = 0, req1_wdata = 0;
  logic rsp1_valid, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic mem_wen, mem_ren;
  logic [31:0] mem [512];
  logic bd_we = 0;
  logic [8:0] bd_idx = 0;
  logic [31:0] bd_d = 0;
  logic [7:0] ref_mem [2048];
  int compared = 0, mismatched = 0, viol = 0, wen_cnt = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.MEM_WORDS(512)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we), .req0_size(req0_size),
    .req0_unsigned(req0_unsigned), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we), .req1_size(req1_size),
    .req1_unsigned(req1_unsigned), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[10:2]];

  // memory macro with a backdoor write port used only for initialisation
  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_d;
    else if (mem_wen) mem[mem_addr[10:2]] <= mem_wdata;
  end

  // protocol invariants and write activity
  always @(negedge clk) begin
    if (!rst && ((mem_wen && mem_ren) || (rsp0_valid && rsp1_valid))) viol <= viol + 1;
    if (mem_wen) wen_cnt <= wen_cnt + 1;
  end

  function automatic logic [31:0] ref_word(input int i);
    return {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
  endfunction

  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
    return sz == 3 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0) || a / 4 >= 512;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic u, input logic [31:0] a);
    int unsigned v, n;
    n = 1 << sz;
    v = 0;
    for (int i = int'(n) - 1; i >= 0; i--) v = v * 256 + ref_mem[int'(a) + i];
    if (!u && n < 4 && v >= (32'd1 << (8*n-1))) v = v - (32'd1 << (8*n));
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < (1 << sz); i++) ref_mem[int'(a) + i] = 8'(d >> (8*i));
  endtask

  task automatic set_req(input int p, input logic v, input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_size = sz; req0_unsigned = u; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_size = sz; req1_unsigned = u; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic do_req(input int p, input logic we, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    logic acc, r;
    acc = 0;
    rd = 'x;
    er = 1'bx;
    lat = -1;
    @(posedge clk);
    #1 set_req(p, 1, we, sz, u, a, d);
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      r = p == 0 ? req0_ready : req1_ready;
      @(posedge clk);
      #1 acc = r;
    end
    set_req(p, 0, 0, 0, 0, 0, 0);
    if (!acc) return;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (p == 0 ? rsp0_valid : rsp1_valid) begin
        lat = k;
        rd = p == 0 ? rsp0_rdata : rsp1_rdata;
        er = p == 0 ? rsp0_err : rsp1_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1;
    set_req(0, 1, 0, 2, 0, 32'h10, 0);
    for (int i = 0; i < 512; i++) begin
      bd_we = 1; bd_idx = 9'(i); bd_d = $urandom;
      {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]} = bd_d;
      @(posedge clk);
      #1;
    end
    bd_we = 0;
    @(negedge clk);
    compared++;
    if ({req0_ready, req1_ready, mem_wen, mem_ren, rsp0_valid, rsp1_valid} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl got %b required 000000", {req0_ready, req1_ready, mem_wen, mem_ren, rsp0_valid, rsp1_valid});
    end
    compared++;
    if (mem_addr !== 0 || mem_wdata !== 0) begin
      mismatched++;
      $display("FAIL reset_mem got addr=%h wdata=%h required 0", mem_addr, mem_wdata);
    end
    set_req(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    compared++;
    if (rsp0_rdata !== 0 || rsp1_rdata !== 0 || rsp0_err !== 0 || rsp1_err !== 0) begin
      mismatched++;
      $display("FAIL reset_rsp got %h %h required 0", rsp0_rdata, rsp1_rdata);
    end
  endtask

  task automatic test_word;
    logic [31:0] rd; logic er; int lat;
    do_req(0, 1, 2, 0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    ref_store(2, 32'h10, 32'hDEADBEEF);
    compared++;
    if (lat !== 1 || er !== 0 || rd !== 0) begin
      mismatched++;
      $display("FAIL sw_rsp got lat=%0d err=%b rd=%h required lat=1 err=0 rd=0", lat, er, rd);
    end
    do_req(0, 0, 2, 0, 32'h10, 0, rd, er, lat);
    compared++;
    if (lat !== 1 || er !== 0 || rd !== 32'hDEADBEEF) begin
      mismatched++;
      $display("FAIL lw_rsp got lat=%0d err=%b rd=%h required lat=1 err=0 rd=deadbeef", lat, er, rd);
    end
  endtask

  task automatic test_byte_merge;
    logic [31:0] rd; logic er; int lat;
    do_req(1, 1, 2, 0, 32'h10, 32'h11223344, rd, er, lat);
    ref_store(2, 32'h10, 32'h11223344);
    do_req(0, 1, 0, 0, 32'h13, 32'hA5, rd, er, lat);
    ref_store(0, 32'h13, 32'hA5);
    compared++;
    if (lat !== 2 || er !== 0) begin
      mismatched++;
      $display("FAIL sb_latency got lat=%0d err=%b required lat=2 err=0", lat, er);
    end
    compared++;
    if (mem[4] !== 32'hA5223344) begin
      mismatched++;
      $display("FAIL sb_merge got %h required a5223344", mem[4]);
    end
    do_req(0, 0, 0, 0, 32'h13, 0, rd, er, lat);
    compared++;
    if (rd !== 32'hFFFFFFA5 || lat !== 1) begin
      mismatched++;
      $display("FAIL lb_signed got %h lat=%0d required ffffffa5 lat=1", rd, lat);
    end
    do_req(1, 0, 0, 1, 32'h13, 0, rd, er, lat);
    compared++;
    if (rd !== 32'h000000A5) begin
      mismatched++;
      $display("FAIL lbu got %h required 000000a5", rd);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat, w0;
    logic [1:0] sz [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
    logic [31:0] ad [4] = '{32'h5, 32'h802, 32'h20, 32'h800};
    logic wr [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    w0 = wen_cnt;
    for (int i = 0; i < 4; i++) begin
      do_req(i % 2, wr[i], sz[i], 0, ad[i], 32'hCAFEF00D, rd, er, lat);
      compared++;
      if (er !== 1 || rd !== 0 || lat !== 1) begin
        mismatched++;
        $display("FAIL err_case%0d got err=%b rd=%h lat=%0d required err=1 rd=0 lat=1", i, er, rd, lat);
      end
    end
    compared++;
    if (wen_cnt !== w0) begin
      mismatched++;
      $display("FAIL err_no_write got %0d writes required 0", wen_cnt - w0);
    end
    do_req(0, 0, 2, 0, 32'h7FC, 0, rd, er, lat);
    compared++;
    if (er !== 0 || rd !== ref_word(511)) begin
      mismatched++;
      $display("FAIL last_word got err=%b rd=%h required err=0 rd=%h", er, rd, ref_word(511));
    end
  endtask

  task automatic test_alternate;
    logic [31:0] ad [2] = '{32'h20, 32'h24};
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    set_req(0, 1, 0, 2, 0, ad[0], 0);
    set_req(1, 1, 0, 2, 0, ad[1], 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      compared++;
      if ({req0_ready, req1_ready} !== (i % 2 == 0 ? 2'b10 : 2'b01)) begin
        mismatched++;
        $display("FAIL rr_grant cycle%0d got %b required %b", i, {req0_ready, req1_ready}, (i % 2 == 0 ? 2'b10 : 2'b01));
      end
      if (i > 0) begin
        compared++;
        if ({rsp0_valid, rsp1_valid} !== ((i - 1) % 2 == 0 ? 2'b10 : 2'b01) ||
            ((i - 1) % 2 == 0 ? rsp0_rdata : rsp1_rdata) !== ref_word(8 + (i - 1) % 2)) begin
          mismatched++;
          $display("FAIL rr_rsp cycle%0d got v=%b d0=%h d1=%h", i, {rsp0_valid, rsp1_valid}, rsp0_rdata, rsp1_rdata);
        end
      end
      @(posedge clk);
      #1;
    end
    set_req(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (req0_ready !== 1) begin
        mismatched++;
        $display("FAIL lone_b2b cycle%0d got ready=%b required 1", i, req0_ready);
      end
      @(posedge clk);
      #1;
    end
    set_req(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_merge;
    logic [31:0] rd; logic er; int lat, seen;
    @(posedge clk);
    #1 set_req(0, 1, 1, 0, 0, 32'h41, 32'h77);
    @(negedge clk);
    compared++;
    if (req0_ready !== 1) begin
      mismatched++;
      $display("FAIL rm_accept got %b required 1", req0_ready);
    end
    @(posedge clk);
    #1 set_req(0, 0, 0, 0, 0, 0, 0);
    rst = 1;
    @(negedge clk);
    compared++;
    if (mem_wen !== 0) begin
      mismatched++;
      $display("FAIL rm_wen got %b required 0", mem_wen);
    end
    @(posedge clk);
    #1 rst = 0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen += int'(rsp0_valid) + int'(rsp1_valid);
    end
    compared++;
    if (seen !== 0 || mem[16] !== ref_word(16)) begin
      mismatched++;
      $display("FAIL rm_abort got rsp=%0d word=%h required rsp=0 word=%h", seen, mem[16], ref_word(16));
    end
    do_req(0, 0, 0, 1, 32'h41, 0, rd, er, lat);
    compared++;
    if (rd !== ref_load(0, 1, 32'h41) || er !== 0 || lat !== 1) begin
      mismatched++;
      $display("FAIL rm_next got %h lat=%0d required %h lat=1", rd, lat, ref_load(0, 1, 32'h41));
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_w;
    @(posedge clk);
    #1 set_req(1, 1, 1, 1, 0, 32'h2, 32'h1234BEEF);
    @(negedge clk);
    compared++;
    if (req1_ready !== 1) begin
      mismatched++;
      $display("FAIL b2b_p1_accept got %b required 1", req1_ready);
    end
    @(posedge clk);
    #1 set_req(1, 0, 0, 0, 0, 0, 0);
    set_req(0, 1, 0, 2, 0, 32'h0, 0);
    ref_store(1, 32'h2, 32'h1234BEEF);
    exp_w = ref_word(0);
    @(negedge clk);
    compared++;
    if (req0_ready !== 0 || mem_wen !== 1 || mem_wdata !== exp_w || mem_addr !== 0) begin
      mismatched++;
      $display("FAIL b2b_merge got rdy0=%b wen=%b wdata=%h required rdy0=0 wen=1 wdata=%h", req0_ready, mem_wen, mem_wdata, exp_w);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    compared++;
    if (req0_ready !== 1 || rsp1_valid !== 1 || rsp1_err !== 0 || rsp1_rdata !== 0) begin
      mismatched++;
      $display("FAIL b2b_after got rdy0=%b rsp1=%b required 1 1", req0_ready, rsp1_valid);
    end
    @(posedge clk);
    #1 set_req(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    compared++;
    if (rsp0_valid !== 1 || rsp0_rdata !== exp_w) begin
      mismatched++;
      $display("FAIL b2b_p0_load got v=%b d=%h required v=1 d=%h", rsp0_valid, rsp0_rdata, exp_w);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, a, d, erd; logic er, we, u, ee; logic [1:0] sz; int lat, el, p, bad;
    for (int n = 0; n < 60; n++) begin
      p = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      sz = $urandom_range(0, 9) == 9 ? 2'd3 : 2'($urandom_range(0, 2));
      a = ($urandom_range(0, 15) == 0 ? 512 + $urandom_range(0, 1000) : $urandom_range(0, 511)) * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 7) != 0) a = sz == 1 ? a & ~32'h1 : sz == 2 ? a & ~32'h3 : a;
      d = $urandom;
      ee = ref_err(sz, a);
      el = ee || !we || sz == 2 ? 1 : 2;
      erd = ee || we ? 0 : ref_load(sz, u, a);
      if (!ee && we) ref_store(sz, a, d);
      do_req(p, we, sz, u, a, d, rd, er, lat);
      compared++;
      if (rd !== erd || er !== ee || lat !== el) begin
        mismatched++;
        $display("FAIL rand%0d p%0d we=%b sz=%0d a=%h got rd=%h err=%b lat=%0d required rd=%h err=%b lat=%0d",
                 n, p, we, sz, a, rd, er, lat, erd, ee, el);
      end
    end
    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_word(i)) bad++;
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL mem_image got %0d differing words required 0", bad);
    end
  endtask

  task automatic test_invariants;
    compared++;
    if (viol !== 0) begin
      mismatched++;
      $display("FAIL invariants got %0d violations required 0", viol);
    end
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte_merge;
    test_errors;
    test_alternate;
    test_reset_merge;
    test_back_to_back;
    test_random;
    test_invariants;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
